// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of a shared word-access memory.
// Misaligned/out-of-range accesses are answered with an error and never strobe the array.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_BYTES   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wd0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rd0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wd1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rd1,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] wd,
    input  logic [31:0] rd,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Winner selection: a lone request wins, a tie goes to whoever did not win last.
    logic        win;
    logic [31:0] win_addr;
    logic        win_bad;

    assign win      = (req0 && req1) ? ~last_grant_q : req1;
    assign win_addr = win ? addr1 : addr0;
    assign win_bad  = (win_addr[1:0] != 2'b00) || (win_addr > LAST_WORD);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = win;
                    last_grant_d = win;
                    we_d         = win ? we1 : we0;
                    addr_d       = win_addr;
                    wd_d         = win ? wd1 : wd0;
                    rdata_d      = '0;
                    if (win_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = rd;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Write strobe only in the last wait cycle, and never while reset is held.
    assign MemRead  = (state_q == ACCESS) && !we_q;
    assign MemWrite = rst_n && (state_q == ACCESS) && we_q && (cnt_q == 4'd0);
    assign addr     = addr_q;
    assign wd       = wd_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    assign ack0 = (state_q == RESP) && !grant_q;
    assign ack1 = (state_q == RESP) &&  grant_q;
    assign err0 = ack0 && err_q;
    assign err1 = ack1 && err_q;
    assign rd0  = ack0 ? rdata_q : '0;
    assign rd1  = ack1 ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, contention and reset sequences,
// and random single-master traffic checked against a transaction-level model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rd0, rd1;
    logic        MemRead, MemWrite, busy, grant_id;
    logic [31:0] addr, wd, rd;

    logic        req0_z, ack0_z, err0_z, ack1_z, err1_z;
    logic        MemRead_z, MemWrite_z, busy_z, grant_id_z;
    logic [31:0] addr0_z, rd0_z, rd1_z, addr_z, wd_z, rd_z;

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_mem    [0:255];
    logic [31:0] model_mem [0:255];

    mem_arbiter #(.WAIT_CYCLES(1), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0),
        .ack0(ack0), .err0(err0), .rd0(rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1),
        .ack1(ack1), .err1(err1), .rd1(rd1),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd), .rd(rd),
        .busy(busy), .grant_id(grant_id)
    );

    mem_arbiter #(.WAIT_CYCLES(0), .MEM_BYTES(1024)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_z), .we0(1'b0), .addr0(addr0_z), .wd0(32'h0),
        .ack0(ack0_z), .err0(err0_z), .rd0(rd0_z),
        .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wd1(32'h0),
        .ack1(ack1_z), .err1(err1_z), .rd1(rd1_z),
        .MemRead(MemRead_z), .MemWrite(MemWrite_z), .addr(addr_z), .wd(wd_z), .rd(rd_z),
        .busy(busy_z), .grant_id(grant_id_z)
    );

    // Environment memories: a word array for the main instance, an address hash for the other.
    always @(posedge clk) if (MemWrite) tb_mem[addr[9:2]] <= wd;
    assign rd   = tb_mem[addr[9:2]];
    assign rd_z = addr_z ^ 32'h5A5A0000;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((MemRead && MemWrite) || (ack0 && ack1)) begin
                errors++;
                $display("FAIL exclusivity: rdwr=%b%b acks=%b%b required no overlap",
                         MemRead, MemWrite, ack0, ack1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a > 32'd1020);
    endfunction

    // One transaction from an idle arbiter; lat counts cycles from the grant cycle to ack.
    task automatic do_txn(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] r,
                          output int nrd, output int nwr);
        if (m) begin req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wd0 = d; end
        lat = 0; nrd = 0; nwr = 0; e = 1'b0; r = '0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                if (m) begin addr1 = $urandom; wd1 = $urandom; we1 = ~w; end
                else   begin addr0 = $urandom; wd0 = $urandom; we0 = ~w; end
            end
            if (MemRead)  nrd++;
            if (MemWrite) nwr++;
            if (m ? ack1 : ack0) begin
                e = m ? err1 : err0;
                r = m ? rd1 : rd0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        bit          err;
        int          lat;
        logic [31:0] rdv;
    } vec_t;

    initial begin
        vec_t        tbl [10];
        int          lat, nrd, nwr;
        logic        e;
        logic [31:0] r;
        int          order [$];
        logic [31:0] rdv [$];
        int          cyc;

        tbl[0] = '{1'b1, 1'b1, 32'd8,    32'hDEADBEEF, 1'b0, 3, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'd8,    32'h0,        1'b0, 3, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b0, 32'd6,    32'h0,        1'b1, 1, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'd1022, 32'h0,        1'b1, 1, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'd1020, 32'h12345678, 1'b0, 3, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b0, 3, 32'h12345678};
        tbl[6] = '{1'b0, 1'b1, 32'd1024, 32'h55555555, 1'b1, 1, 32'h0};
        tbl[7] = '{1'b0, 1'b1, 32'd12,   32'hCAFEF00D, 1'b0, 3, 32'h0};
        tbl[8] = '{1'b1, 1'b0, 32'd12,   32'h0,        1'b0, 3, 32'hCAFEF00D};
        tbl[9] = '{1'b0, 1'b0, 32'd1021, 32'h0,        1'b1, 1, 32'h0};

        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = (i * 32'h01010101) ^ 32'hA5A5A5A5;
            model_mem[i] = (i * 32'h01010101) ^ 32'hA5A5A5A5;
        end
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wd0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
        req0_z = 0; addr0_z = 0;

        @(posedge clk); @(posedge clk); #1;
        check("rst ack0", 32'(ack0), 0);
        check("rst ack1", 32'(ack1), 0);
        check("rst err0", 32'(err0), 0);
        check("rst err1", 32'(err1), 0);
        check("rst rd0", rd0, 0);
        check("rst rd1", rd1, 0);
        check("rst addr", addr, 0);
        check("rst wd", wd, 0);
        check("rst MemRead", 32'(MemRead), 0);
        check("rst MemWrite", 32'(MemWrite), 0);
        check("rst busy", 32'(busy), 0);
        check("rst grant_id", 32'(grant_id), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].d, lat, e, r, nrd, nwr);
            check($sformatf("vec%0d lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].err));
            if (!tbl[i].we) check($sformatf("vec%0d rd", i), r, tbl[i].rdv);
            check($sformatf("vec%0d nread", i), 32'(nrd), (!tbl[i].err && !tbl[i].we) ? 2 : 0);
            check($sformatf("vec%0d nwrite", i), 32'(nwr), (!tbl[i].err && tbl[i].we) ? 1 : 0);
            if (tbl[i].we && !tbl[i].err) model_mem[tbl[i].a[9:2]] = tbl[i].d;
        end

        // Contention from reset: both masters hold their read requests.
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 32'h40;
        req1 = 1; we1 = 0; addr1 = 32'h80;
        cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (ack0) begin order.push_back(0); rdv.push_back(rd0); check("cont rd1 idle", rd1, 0); end
            if (ack1) begin order.push_back(1); rdv.push_back(rd1); check("cont rd0 idle", rd0, 0); end
        end
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        check("cont acks", 32'(order.size()), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            check($sformatf("cont grant%0d", i), 32'(order[i]), 32'(i % 2));
            check($sformatf("cont data%0d", i), rdv[i],
                  (order[i] == 0) ? model_mem[32'h40 >> 2] : model_mem[32'h80 >> 2]);
        end

        for (int i = 0; i < 40; i++) begin
            bit          m, w, bad;
            logic [31:0] a, d;
            int          sel;
            m = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 32'($urandom_range(0, 255)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, 1023)) | 32'd1;
            else if (sel == 8) a = 32'd1024 + 32'($urandom_range(0, 4095));
            else               a = 32'hFFFFFFFC;
            bad = bad_addr(a);
            do_txn(m, w, a, d, lat, e, r, nrd, nwr);
            check($sformatf("rnd%0d lat", i), 32'(lat), bad ? 1 : 3);
            check($sformatf("rnd%0d err", i), 32'(e), 32'(bad));
            if (!w) check($sformatf("rnd%0d rd", i), r, bad ? 32'h0 : model_mem[a[9:2]]);
            check($sformatf("rnd%0d nread", i), 32'(nrd), (!bad && !w) ? 2 : 0);
            check($sformatf("rnd%0d nwrite", i), 32'(nwr), (!bad && w) ? 1 : 0);
            if (w && !bad) model_mem[a[9:2]] = d;
        end

        // Reset asserted during the final wait cycle of a write to 16.
        req1 = 1; we1 = 1; addr1 = 32'd16; wd1 = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rstmid MemWrite", 32'(MemWrite), 0);
        @(posedge clk); #1;
        check("rstmid busy", 32'(busy), 0);
        check("rstmid ack1", 32'(ack1), 0);
        check("rstmid mem", tb_mem[4], model_mem[4]);
        rst_n = 1'b1; req1 = 0; we1 = 0;
        @(posedge clk); #1;

        // Zero wait states: read completes two cycles after the grant cycle.
        req0_z = 1; addr0_z = 32'd4;
        lat = 0; nrd = 0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (MemRead_z) nrd++;
            if (ack0_z) break;
        end
        check("w0 lat", 32'(lat), 2);
        check("w0 nread", 32'(nrd), 1);
        check("w0 rd", rd0_z, 32'h5A5A0004);
        check("w0 err", 32'(err0_z), 0);
        req0_z = 0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
